// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: small FIFO feeding a start/data/parity/stop framer.
// Optional break generation is compiled in with `define UART_TX_BREAK_EN.
module uart_tx_buffered #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [DATA_WIDTH-1:0]              p_data,
    input  logic                               data_valid,
    output logic                               ready,
    input  logic                               par_en,
    input  logic                               par_type,
    input  logic                               stop2,
    input  logic [DIV_WIDTH-1:0]               baud_div,
    input  logic                               send_break,
    output logic                               tx_out,
    output logic                               busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(DATA_WIDTH);

`ifdef UART_TX_BREAK_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, BREAK} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;
    logic unused_break;
    assign unused_break = send_break;
`endif

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]         count_reg;
    logic                  push, pop;
    logic [DATA_WIDTH-1:0] head;

    state_t                state_reg, state_next;
    logic [DATA_WIDTH-1:0] shift_reg, shift_next;
    logic [BW-1:0]         bit_cnt_reg, bit_cnt_next;
    logic [DIV_WIDTH-1:0]  div_cnt_reg, div_cnt_next;
    logic [DIV_WIDTH-1:0]  div_reg, div_next;
    logic                  par_en_reg, par_en_next;
    logic                  stop2_reg, stop2_next;
    logic                  par_bit_reg, par_bit_next;
    logic                  tx_reg, tx_next;
    logic                  load, bit_end;

    assign ready      = (count_reg != CW'(FIFO_DEPTH));
    assign push       = data_valid && ready;
    assign head       = mem[rd_ptr_reg];
    assign fifo_count = count_reg;
    assign busy       = (state_reg != IDLE);
    assign tx_out     = tx_reg;
    assign bit_end    = (div_cnt_reg == div_reg - DIV_WIDTH'(1));

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg] <= p_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt_reg;
        div_cnt_next = div_cnt_reg;
        div_next     = div_reg;
        par_en_next  = par_en_reg;
        stop2_next   = stop2_reg;
        par_bit_next = par_bit_reg;
        load         = 1'b0;
        pop          = 1'b0;

        // Every state except IDLE/BREAK times its bit with the divider.
        if (state_reg != IDLE && state_reg != STOP2 + 3'd1 && !bit_end)
            div_cnt_next = div_cnt_reg + DIV_WIDTH'(1);
        else
            div_cnt_next = '0;

        case (state_reg)
            IDLE: begin
`ifdef UART_TX_BREAK_EN
                if (send_break)
                    state_next = BREAK;
                else
`endif
                if (count_reg != '0)
                    load = 1'b1;
            end
            START: if (bit_end) state_next = DATA;
            DATA: if (bit_end) begin
                if (bit_cnt_reg == BW'(DATA_WIDTH - 1))
                    state_next = par_en_reg ? PARITY : STOP1;
                else begin
                    bit_cnt_next = bit_cnt_reg + BW'(1);
                    shift_next   = shift_reg >> 1;
                end
            end
            PARITY: if (bit_end) state_next = STOP1;
            STOP1: if (bit_end) begin
                if (stop2_reg)               state_next = STOP2;
                else if (count_reg != '0)    load = 1'b1;
                else                         state_next = IDLE;
            end
            STOP2: if (bit_end) begin
                if (count_reg != '0) load = 1'b1;
                else                 state_next = IDLE;
            end
`ifdef UART_TX_BREAK_EN
            BREAK: if (!send_break) state_next = IDLE;
`endif
            default: state_next = IDLE;
        endcase

        // Frame setup: pop the head word and freeze the line settings.
        if (load) begin
            pop          = 1'b1;
            state_next   = START;
            shift_next   = head;
            bit_cnt_next = '0;
            div_cnt_next = '0;
            par_bit_next = (^head) ^ par_type;
            par_en_next  = par_en;
            stop2_next   = stop2;
            div_next     = (baud_div == '0) ? DIV_WIDTH'(1) : baud_div;
        end

        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            PARITY:  tx_next = par_bit_next;
`ifdef UART_TX_BREAK_EN
            BREAK:   tx_next = 1'b0;
`endif
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
            div_cnt_reg <= '0;
            div_reg     <= '0;
            par_en_reg  <= 1'b0;
            stop2_reg   <= 1'b0;
            par_bit_reg <= 1'b0;
            tx_reg      <= 1'b1;
        end else begin
            state_reg   <= state_next;
            shift_reg   <= shift_next;
            bit_cnt_reg <= bit_cnt_next;
            div_cnt_reg <= div_cnt_next;
            div_reg     <= div_next;
            par_en_reg  <= par_en_next;
            stop2_reg   <= stop2_next;
            par_bit_reg <= par_bit_next;
            tx_reg      <= tx_next;
        end
    end
endmodule

// File: doc/uart_tx_buffered.md
UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

Interface
REQ-001 Parameter DATA_WIDTH, default 8, data bits per frame, legal range 5..9.
REQ-002 Parameter FIFO_DEPTH, default 4, transmit FIFO entries, power of two, 2 or more.
REQ-003 Parameter DIV_WIDTH, default 16, width of the bit-period divider.
REQ-004 clk  input  1  single clock; all flops rising-edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 p_data  input  DATA_WIDTH  word to transmit.
REQ-007 data_valid  input  1  write request for p_data.
REQ-008 ready  output  1  FIFO can accept a word (not full).
REQ-009 par_en  input  1  parity bit enable.
REQ-010 par_type  input  1  parity type: 0 even, 1 odd.
REQ-011 stop2  input  1  0 gives one stop bit; 1 gives two stop bits.
REQ-012 baud_div  input  DIV_WIDTH  clk cycles per bit.
REQ-013 send_break  input  1  break request (used only with UART_TX_BREAK_EN).
REQ-014 tx_out  output  1  registered serial line, idle high.
REQ-015 busy  output  1  FSM is not in IDLE.
REQ-016 fifo_count  output  $clog2(FIFO_DEPTH+1)  occupied FIFO entries.

Function
REQ-017 A write is accepted on a rising edge with data_valid=1 and ready=1; with ready=0 the word is dropped and no state changes.
REQ-018 ready SHALL be !(fifo_count==FIFO_DEPTH); a pop on the same edge does not free space for a write.
REQ-019 A simultaneous accepted write and pop SHALL leave fifo_count unchanged and preserve FIFO order.
REQ-020 FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2, BREAK.
REQ-021 In IDLE with the FIFO non-empty, the next edge pops the head word, samples par_en/par_type/stop2/baud_div for the whole frame, and enters START.
REQ-022 Latency: a word written into an empty FIFO while IDLE at edge k drives the start bit (tx_out=0) from edge k+1.
REQ-023 Each bit lasts exactly max(baud_div,1) cycles; baud_div=0 behaves as 1.
REQ-024 DATA shifts DATA_WIDTH bits out LSB first.
REQ-025 PARITY is entered only if par_en was latched; parity bit = XOR(data) XOR par_type.
REQ-026 STOP1 drives 1; STOP2 (also 1) follows only if stop2 was latched.
REQ-027 At the end of the last stop bit: if the FIFO is non-empty, pop and enter START with no idle gap; otherwise enter IDLE.
REQ-028 Input changes to par_en, par_type, stop2 and baud_div mid-frame SHALL NOT affect the frame in progress.
REQ-029 In IDLE and in every stop state, tx_out=1.

Reset
REQ-030 While rst=0, asynchronously: tx_out=1, busy=0, FIFO empty, fifo_count=0, ready=1, FSM=IDLE, bit counter and divider counter=0.
REQ-031 Reset asserted mid-frame SHALL abort the frame and discard all queued words.

Configuration
REQ-032 With UART_TX_BREAK_EN defined: in IDLE, send_break=1 enters BREAK on the next edge (this takes priority over a pop); BREAK drives tx_out=0 and busy=1 and does not pop the FIFO; when send_break=0, the next edge returns to IDLE.
REQ-033 send_break is never sampled mid-frame.
REQ-034 Without UART_TX_BREAK_EN: send_break is ignored, the BREAK state and its logic are absent, and all other behaviour is identical.

Verification
REQ-035 baud_div=4, par_en=0, stop2=0, write 0xA5 -> tx_out bits 0,1,0,1,0,0,1,0,1,1, 4 cycles each (40 cycles), then IDLE with busy=0.
REQ-036 baud_div=2, par_en=1, write 0x07 with par_type=0 -> parity bit 1; with par_type=1 -> parity bit 0; each frame 22 cycles.
REQ-037 baud_div=8, write 6 words on consecutive cycles -> word0 popped; words 1-4 queued; word5 rejected; ready=0; fifo_count=4; transmission order 0,1,2,3,4.
REQ-038 stop2=1, par_en=1, baud_div=3, two queued words -> start bit of the second frame immediately follows STOP2 of the first; total 2*12*3=72 cycles low-to-idle.
REQ-039 rst pulsed low during the DATA bit 3 of a frame with 2 words queued -> tx_out=1 immediately; fifo_count=0; no further frames.
REQ-040 With UART_TX_BREAK_EN, IDLE, send_break high 20 cycles with 1 word queued -> tx_out=0 for 20 cycles, fifo_count stays 1; the frame starts after return to IDLE.
